// File: rtl/rca_sweep_checker_if.sv
// Adder-facing bus of the sweep checker: operands out, sum/carry back.
// The checker takes the master modport and the adder takes the slave modport.
interface rca_sweep_checker_if #(
    parameter int SIZE = 2
);
    logic [SIZE-1:0] PortA_nbit;
    logic [SIZE-1:0] PortB_nbit;
    logic            PortCin_nbit;
    logic [SIZE-1:0] PortS_nbit;
    logic            PortCout_nbit;

    modport master (
        output PortA_nbit,
        output PortB_nbit,
        output PortCin_nbit,
        input  PortS_nbit,
        input  PortCout_nbit
    );

    modport slave (
        input  PortA_nbit,
        input  PortB_nbit,
        input  PortCin_nbit,
        output PortS_nbit,
        output PortCout_nbit
    );
endinterface

// File: rtl/rca_sweep_checker.sv
// Exhaustive stimulus and checking stage for an n-bit ripple-carry adder.
// Operands step through {Cin,A,B} in ascending order. Each vector is held for
// SETTLE_CYC cycles and then checked for one cycle against A+B+Cin.
module rca_sweep_checker #(
    parameter int SIZE       = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    rca_sweep_checker_if.master   adder,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2*SIZE+1:0]     vec_count,
    output logic [15:0]           err_count,
    output logic                  fail_valid,
    output logic [2*SIZE:0]       fail_vec
);

    localparam int VW = 2*SIZE + 2;
    localparam int FW = 2*SIZE + 1;
    localparam int SW = SIZE + 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [SIZE-1:0] r_a;
    logic [SIZE-1:0] r_b;
    logic            r_cin;
    logic [CW-1:0]   r_settleCnt;
    logic [VW-1:0]   r_vecCount;
    logic [15:0]     r_errCount;
    logic            r_failValid;
    logic [FW-1:0]   r_failVec;

    logic            w_settleDone;
    logic            w_lastVec;
    logic            w_startAccept;
    logic [SW-1:0]   w_expected;
    logic [SW-1:0]   w_actual;
    logic            w_mismatch;
    logic [FW-1:0]   w_nextVec;

    assign w_settleDone  = (r_settleCnt == CW'(SETTLE_CYC - 1));
    assign w_lastVec     = r_cin && (&r_a) && (&r_b);
    assign w_startAccept = start && !abort && (r_state == IDLE || r_state == DONE);
    assign w_expected    = {1'b0, r_a} + {1'b0, r_b} + SW'(r_cin);
    assign w_actual      = {adder.PortCout_nbit, adder.PortS_nbit};
    assign w_mismatch    = (w_expected != w_actual);
    assign w_nextVec     = {r_cin, r_a, r_b} + FW'(1);

    assign adder.PortA_nbit   = r_a;
    assign adder.PortB_nbit   = r_b;
    assign adder.PortCin_nbit = r_cin;
    assign vec_count          = r_vecCount;
    assign err_count          = r_errCount;
    assign fail_valid         = r_failValid;
    assign fail_vec           = r_failVec;
    assign pass               = done && (r_errCount == 16'h0000);

    // State register for the sweep sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status decode; abort overrides every other transition.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_nextState = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (w_settleDone) w_nextState = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                w_nextState = w_lastVec ? DONE : DRIVE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_nextState = DRIVE;
            end
            default: w_nextState = IDLE;
        endcase
        if (abort) w_nextState = IDLE;
    end

    // Operand stepping, settle timing, counters and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_settleCnt <= '0;
            r_vecCount  <= '0;
            r_errCount  <= '0;
            r_failValid <= 1'b0;
            r_failVec   <= '0;
        end else if (abort) begin
            r_settleCnt <= '0;
        end else if (w_startAccept) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_settleCnt <= '0;
            r_vecCount  <= '0;
            r_errCount  <= '0;
            r_failValid <= 1'b0;
            r_failVec   <= '0;
        end else if (r_state == DRIVE) begin
            r_settleCnt <= w_settleDone ? '0 : r_settleCnt + CW'(1);
        end else if (r_state == CHECK) begin
            r_settleCnt <= '0;
            r_vecCount  <= r_vecCount + VW'(1);
            if (w_mismatch) begin
                if (r_errCount != 16'hFFFF) r_errCount <= r_errCount + 16'd1;
                if (!r_failValid) begin
                    r_failValid <= 1'b1;
                    r_failVec   <= {r_cin, r_a, r_b};
                end
            end
            if (!w_lastVec) {r_cin, r_a, r_b} <= w_nextVec;
        end
    end

endmodule

// File: doc/rca_sweep_checker.md
# rca_sweep_checker

Self-checking stimulus stage placed directly upstream of the n-bit ripple-carry adder (`FAnbit_RCA`). On a start pulse it drives the adder's PortA/PortB/PortCin through every input combination, Cin outer, A middle, B inner, ascending. It samples the adder's sum and carry after a programmable settle time and compares them against an internally computed reference. Error count, first failing vector and pass/done status are exposed for LEDs or a display stage.

## Interface
- SIZE, 2, operand width n (1..8)
- SETTLE_CYC, 1, cycles operands are held before the result is sampled (>=1)
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a sweep
- abort  in  1  stop the sweep and return to IDLE
- PortA_nbit  out  SIZE  operand A to adder (registered)
- PortB_nbit  out  SIZE  operand B to adder (registered)
- PortCin_nbit  out  1  carry-in to adder (registered)
- PortS_nbit  in  SIZE  sum from adder
- PortCout_nbit  in  1  carry-out from adder
- busy  out  1  sweep in progress (DRIVE or CHECK)
- done  out  1  sweep completed, held until next start/abort
- pass  out  1  done && err_count==0
- vec_count  out  2*SIZE+2  vectors checked
- err_count  out  16  mismatching vectors, saturates at 16'hFFFF
- fail_valid  out  1  at least one mismatch captured
- fail_vec  out  2*SIZE+1  {Cin,A,B} of first mismatch

## Operation
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE/DONE + start: clear operands, vec_count, err_count, fail_valid and fail_vec. Clear done. Go to DRIVE.
- start in DRIVE/CHECK is ignored.
- DRIVE: hold operands for SETTLE_CYC cycles (internal settle counter), then go to CHECK.
- CHECK (one cycle): expected = A + B + Cin computed at SIZE+1 bits. Compare against {PortCout_nbit, PortS_nbit}.
  - On the exiting edge: vec_count += 1.
  - On mismatch: err_count += 1 (saturating). If fail_valid==0, capture fail_vec={Cin,A,B} and set fail_valid.
- Advance after CHECK: B+1. On B wrap to 0, A+1. On A wrap to 0, Cin goes 0->1.
- Last vector is Cin=1, A=B=all-ones. After its CHECK, go to DONE with no advance, so operands hold the last vector.
- Total vectors = 2^(2*SIZE+1). For SIZE=2 that is 32.
- abort (any state, priority over start): go to IDLE next edge. busy=0, done=0. Operands, counts and fail capture hold.
- pass is combinational from done and err_count.

## Timing
- Reset values:
  - state=IDLE.
  - All operand outputs 0.
  - busy, done, pass, fail_valid = 0.
  - vec_count, err_count, fail_vec = 0.
- Reset mid-sweep zeroes everything immediately (asynchronous). No completion is reported.
- start sampled at edge k: state=DRIVE and operands=0 after edge k. busy rises with DRIVE.
- Per-vector latency is SETTLE_CYC+1 cycles, and the adder output is sampled at least SETTLE_CYC cycles after the operands change.
- done rises on the edge after the final CHECK, which is edge k + 2^(2*SIZE+1)*(SETTLE_CYC+1). busy falls on the same edge.
- Counters update on the CHECK exit edge only. vec_count never wraps, because its width holds the full vector total.
- Simultaneous start and abort: abort wins, and the block goes to IDLE.

## Test plan
- Reset: hold rst_n=0 with random inputs, then release -> all outputs 0, busy=0, done=0.
- Golden sweep (SIZE=2, SETTLE_CYC=1, correct behavioural adder), start at edge 0 -> done=1 after edge 64, vec_count=32, err_count=0, pass=1, fail_valid=0, operands hold A=3, B=3, Cin=1.
- Fault injection: PortS_nbit[0] stuck at 0 -> err_count=16, fail_valid=1, fail_vec=5'b00001, pass=0 at done.
- Busy rules: start pulsed mid-sweep -> ignored, still done after edge 64. Abort at vector 10 -> IDLE next edge, busy=0, done=0, vec_count=10.
- Async reset asserted mid-CHECK, between clock edges -> all outputs 0 immediately. Subsequent start runs a full, clean 32-vector sweep.
- Restart from DONE after the fault run, with the fault removed -> counts and fail capture cleared on the start edge, final err_count=0, pass=1.
